load_align_unit: RTL and testbench



---
 rtl/load_pkg.sv | 20 ++
 rtl/load_extract.sv | 43 ++++
 rtl/load_align_unit.sv | 132 +++++++++++++
 tb/tb_load_align_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// load_pkg: shared encodings for the load-data path.
//   SZ_*     : access size encoding carried on ReqSize (byte/half/word/double)
//   state_t  : sequencer states of load_align_unit
package load_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_t;

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational byte-lane extraction and sign/zero extension.
// Shared with the store-data formatter, so it carries no state.
//   window      : {beat1, beat0}, two consecutive bus words
//   off         : byte offset of the access inside beat0
//   size        : SZ_B / SZ_H / SZ_W / SZ_D
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   result      : extracted, extended XLEN-bit value
module load_extract
    import load_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         window,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [1:0]                size,
    input  logic                      is_unsigned,
    output logic [XLEN-1:0]           result
);

    logic [XLEN-1:0] low;
    logic            fill;
    int              nbits;

    // Addressed byte lands in bit 0; anything above XLEN is never needed.
    assign low = XLEN'(window >> {off, 3'b000});

    always_comb begin
        nbits  = XLEN;
        fill   = 1'b0;
        result = '0;
        case (size)
            SZ_B:    begin nbits = 8;  fill = low[7];      end
            SZ_H:    begin nbits = 16; fill = low[15];     end
            SZ_W:    begin nbits = 32; fill = low[31];     end
            default: begin nbits = XLEN; fill = low[XLEN-1]; end
        endcase
        fill = fill & ~is_unsigned;
        for (int i = 0; i < XLEN; i++) begin
            result[i] = (i < nbits) ? low[i] : fill;
        end
    end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: one-at-a-time load sequencer between MEM and the data bus.
// Issues one aligned bus read, or two when the access straddles a bus word,
// then returns the extracted/extended result with its tag.
//   clk, rst_n                   : clock, async active-low reset
//   ReqValid/ReqReady/ReqAddr/ReqSize/ReqUnsigned/ReqTag : load request
//   MemReqValid/MemReqReady/MemAddr                      : bus read request
//   MemRspValid/MemRspData                               : bus read data
//   RspValid/RspReady/RspData/RspTag/RspErr              : writeback result
module load_align_unit
    import load_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MISALIGNED_EN = 1,
    parameter int TAG_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [XLEN-1:0]  ReqAddr,
    input  logic [1:0]       ReqSize,
    input  logic             ReqUnsigned,
    input  logic [TAG_W-1:0] ReqTag,
    output logic             MemReqValid,
    input  logic             MemReqReady,
    output logic [XLEN-1:0]  MemAddr,
    input  logic             MemRspValid,
    input  logic [XLEN-1:0]  MemRspData,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [XLEN-1:0]  RspData,
    output logic [TAG_W-1:0] RspTag,
    output logic             RspErr
);

    localparam int B    = XLEN / 8;
    localparam int OFFW = $clog2(B);

    state_t           state, state_nxt;
    logic [XLEN-1:0]  base_q, beat0_q, beat1_q;
    logic [1:0]       size_q;
    logic             uns_q, split_q, err_q;
    logic [TAG_W-1:0] tag_q;
    logic [OFFW-1:0]  off_q;

    // ---- request decode (only meaningful in IDLE) ----
    logic [OFFW-1:0] req_off;
    logic [4:0]      req_end;
    logic [2:0]      req_amask;
    logic            req_split, req_mis, req_illegal, req_err;

    assign req_off     = ReqAddr[OFFW-1:0];
    assign req_end     = 5'(req_off) + (5'd1 << ReqSize);
    assign req_split   = req_end > 5'(B);
    assign req_amask   = 3'((4'd1 << ReqSize) - 4'd1);
    assign req_mis     = |(ReqAddr[2:0] & req_amask);
    assign req_illegal = (XLEN == 32) && (ReqSize == SZ_D);
    assign req_err     = req_illegal || ((MISALIGNED_EN == 0) && req_mis);

    // ---- sequencer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ReqValid)    state_nxt = req_err ? RESP : REQ0;
            REQ0:    if (MemReqReady) state_nxt = WAIT0;
            WAIT0:   if (MemRspValid) state_nxt = split_q ? REQ1 : RESP;
            REQ1:    if (MemReqReady) state_nxt = WAIT1;
            WAIT1:   if (MemRspValid) state_nxt = RESP;
            RESP:    if (RspReady)    state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // ---- request fields and beat capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            off_q   <= '0;
        end else begin
            case (state)
                IDLE: if (ReqValid) begin
                    base_q  <= {ReqAddr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    size_q  <= ReqSize;
                    uns_q   <= ReqUnsigned;
                    tag_q   <= ReqTag;
                    off_q   <= req_off;
                    split_q <= req_split;
                    err_q   <= req_err;
                    // Unsplit accesses extract from {0, beat0}.
                    beat1_q <= '0;
                end
                WAIT0: if (MemRspValid) beat0_q <= MemRspData;
                WAIT1: if (MemRspValid) beat1_q <= MemRspData;
                default: ;
            endcase
        end
    end

    // Extraction runs off the held beat registers, so RspData is stable in RESP.
    logic [XLEN-1:0] ext_data;

    load_extract #(.XLEN(XLEN)) u_extract (
        .window      ({beat1_q, beat0_q}),
        .off         (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

    // ---- outputs ----
    assign ReqReady    = (state == IDLE);
    assign MemReqValid = (state == REQ0) || (state == REQ1);
    assign MemAddr     = (state == REQ0) ? base_q :
                         (state == REQ1) ? base_q + XLEN'(B) : '0;
    assign RspValid    = (state == RESP);
    assign RspData     = (RspValid && !err_q) ? ext_data : '0;
    assign RspTag      = RspValid ? tag_q : '0;
    assign RspErr      = RspValid && err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench: scoreboard + monitor for load_align_unit (XLEN=32). One instance with
// misaligned splitting enabled, a second with it disabled for error cases.
module tb_load_align_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
        int          nreq;
        logic [31:0] a0;
        int          lat;
        int          t0;
    } exp_t;

    // ---------------- DUT with splitting ----------------
    logic        req_valid, req_ready, req_unsigned;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [4:0]  req_tag;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [31:0] mem_addr, mem_rsp_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;

    load_align_unit #(.XLEN(32), .MISALIGNED_EN(1), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqAddr(req_addr),
        .ReqSize(req_size), .ReqUnsigned(req_unsigned), .ReqTag(req_tag),
        .MemReqValid(mem_req_valid), .MemReqReady(mem_req_ready), .MemAddr(mem_addr),
        .MemRspValid(mem_rsp_valid), .MemRspData(mem_rsp_data),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data),
        .RspTag(rsp_tag), .RspErr(rsp_err)
    );

    // ---------------- DUT with misaligned = error ----------------
    logic        req_valid0, req_ready0, req_unsigned0;
    logic [31:0] req_addr0;
    logic [1:0]  req_size0;
    logic [4:0]  req_tag0;
    logic        mem_req_valid0, mem_rsp_valid0;
    logic        mem_req_ready0 = 1'b1;
    logic [31:0] mem_rsp_data0 = 32'h80FF7F01;
    logic [31:0] mem_addr0;
    logic        rsp_valid0, rsp_err0;
    logic        rsp_ready0 = 1'b1;
    logic [31:0] rsp_data0;
    logic [4:0]  rsp_tag0;

    load_align_unit #(.XLEN(32), .MISALIGNED_EN(0), .TAG_W(5)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .ReqValid(req_valid0), .ReqReady(req_ready0), .ReqAddr(req_addr0),
        .ReqSize(req_size0), .ReqUnsigned(req_unsigned0), .ReqTag(req_tag0),
        .MemReqValid(mem_req_valid0), .MemReqReady(mem_req_ready0), .MemAddr(mem_addr0),
        .MemRspValid(mem_rsp_valid0), .MemRspData(mem_rsp_data0),
        .RspValid(rsp_valid0), .RspReady(rsp_ready0), .RspData(rsp_data0),
        .RspTag(rsp_tag0), .RspErr(rsp_err0)
    );

    // ---------------- bus responder (main DUT) ----------------
    logic [31:0] w100, w104;
    int          nreq = 0;
    logic [31:0] bus_addr[$];
    int          req_stall = 0;
    logic        hold_b1 = 1'b0;

    initial begin
        logic        pend, stalling;
        logic [31:0] pend_addr, cap_a;
        pend = 1'b0; stalling = 1'b0; pend_addr = '0; cap_a = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (pend && !(hold_b1 && nreq == 2)) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = (pend_addr == 32'h104) ? w104 : w100;
                pend = 1'b0;
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 32'hDEADBEEF;
            end
            if (mem_req_valid) begin
                if (req_stall > 0) begin
                    mem_req_ready = 1'b0;
                    if (!stalling) begin
                        cap_a = mem_addr;
                        stalling = 1'b1;
                    end else chk("mem_addr_hold", mem_addr, cap_a);
                    req_stall--;
                end else begin
                    mem_req_ready = 1'b1;
                    stalling = 1'b0;
                    nreq++;
                    bus_addr.push_back(mem_addr);
                    pend = 1'b1;
                    pend_addr = mem_addr;
                end
            end else mem_req_ready = 1'b1;
        end
    end

    // ---------------- monitor (main DUT) ----------------
    exp_t sb[$];
    int   rsp_stall = 0;

    initial begin
        exp_t        e;
        logic        seen;
        logic [31:0] cap_d;
        logic [4:0]  cap_t;
        seen = 1'b0; cap_d = '0; cap_t = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            rsp_ready = 1'b0;
            if (rst_n && rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen  = 1'b1;
                        cap_d = rsp_data;
                        cap_t = rsp_tag;
                        if (e.lat >= 0) chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                    end
                    if (rsp_stall > 0) begin
                        rsp_stall--;
                        chk("rsp_data_hold", rsp_data, cap_d);
                        chk("rsp_tag_hold", rsp_tag, cap_t);
                        chk("req_ready_busy", req_ready, 0);
                    end else begin
                        rsp_ready = 1'b1;
                        void'(sb.pop_front());
                        seen = 1'b0;
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", rsp_err, e.err);
                        chk("rsp_tag", rsp_tag, e.tag);
                        chk("bus_req_count", 64'(nreq), 64'(e.nreq));
                        if (bus_addr.size() >= 1) chk("bus_addr0", bus_addr[0], e.a0);
                        if (bus_addr.size() >= 2) chk("bus_addr1", bus_addr[1], e.a0 + 32'd4);
                    end
                end
            end
        end
    end

    // ---------------- responder + monitor (error DUT) ----------------
    int   nreq0 = 0;
    exp_t sb0[$];

    initial begin
        logic pend0;
        pend0 = 1'b0;
        mem_rsp_valid0 = 1'b0;
        forever begin
            @(negedge clk);
            mem_rsp_valid0 = pend0;
            pend0 = mem_req_valid0;
            if (mem_req_valid0) nreq0++;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid0) begin
                if (sb0.size() == 0) begin
                    chk("unexpected_rsp0", {63'd0, rsp_valid0}, 64'd0);
                end else begin
                    e = sb0.pop_front();
                    chk("latency0", 64'(cyc - e.t0), 64'(e.lat));
                    chk("rsp_data0", rsp_data0, e.data);
                    chk("rsp_err0", rsp_err0, e.err);
                    chk("rsp_tag0", rsp_tag0, e.tag);
                    chk("bus_req_count0", 64'(nreq0), 64'(e.nreq));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input logic [4:0] tg, input logic [31:0] d, input logic er,
                         input int nr, input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        nreq = 0;
        bus_addr.delete();
        e.data = d; e.tag = tg; e.err = er; e.nreq = nr;
        e.a0 = a & ~32'd3; e.lat = lat; e.t0 = cyc;
        sb.push_back(e);
        req_valid = 1'b1; req_addr = a; req_size = sz; req_unsigned = u; req_tag = tg;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    task automatic issue0(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [4:0] tg, input logic [31:0] d, input logic er,
                          input int nr, input int lat);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready0 && n < 50) begin @(negedge clk); n++; end
        if (!req_ready0) begin
            chk("req_ready0_timeout", 0, 1);
            return;
        end
        nreq0 = 0;
        e.data = d; e.tag = tg; e.err = er; e.nreq = nr;
        e.a0 = '0; e.lat = lat; e.t0 = cyc;
        sb0.push_back(e);
        req_valid0 = 1'b1; req_addr0 = a; req_size0 = sz; req_unsigned0 = u; req_tag0 = tg;
        @(negedge clk);
        req_valid0 = 1'b0;
        n = 0;
        while (sb0.size() != 0 && n < 30) begin @(negedge clk); n++; end
        if (sb0.size() != 0) begin
            chk("rsp0_timeout", 64'(sb0.size()), 0);
            sb0.delete();
        end
    endtask

    initial begin
        int n;
        logic bad;
        req_valid = 1'b0; req_addr = '0; req_size = '0; req_unsigned = 1'b0; req_tag = '0;
        req_valid0 = 1'b0; req_addr0 = '0; req_size0 = '0; req_unsigned0 = 1'b0; req_tag0 = '0;
        w100 = 32'h80FF7F01; w104 = 32'h0;

        // reset values
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_mem_req_valid", mem_req_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_tag", rsp_tag, 0);
        chk("reset_rsp_err", rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // byte loads, word 0x80FF7F01 at 0x100
        issue(32'h103, 2'd0, 1'b0, 5'd1, 32'hFFFFFF80, 1'b0, 1, 3);
        issue(32'h101, 2'd0, 1'b1, 5'd2, 32'h0000007F, 1'b0, 1, 3);
        issue(32'h102, 2'd0, 1'b1, 5'd3, 32'h000000FF, 1'b0, 1, 3);
        issue(32'h102, 2'd0, 1'b0, 5'd4, 32'hFFFFFFFF, 1'b0, 1, 3);
        issue(32'h100, 2'd0, 1'b0, 5'd5, 32'h00000001, 1'b0, 1, 3);

        // half / word aligned
        w100 = 32'h80011234;
        issue(32'h102, 2'd1, 1'b0, 5'd6, 32'hFFFF8001, 1'b0, 1, 3);
        issue(32'h102, 2'd1, 1'b1, 5'd7, 32'h00008001, 1'b0, 1, 3);
        issue(32'h100, 2'd1, 1'b0, 5'd8, 32'h00001234, 1'b0, 1, 3);
        issue(32'h100, 2'd2, 1'b0, 5'd9, 32'h80011234, 1'b0, 1, 3);

        // misaligned, split across 0x100/0x104
        w100 = 32'h11223344; w104 = 32'h55667788;
        issue(32'h103, 2'd2, 1'b0, 5'd10, 32'h66778811, 1'b0, 2, 5);
        issue(32'h102, 2'd2, 1'b0, 5'd11, 32'h77881122, 1'b0, 2, 5);
        issue(32'h103, 2'd1, 1'b0, 5'd12, 32'hFFFF8811, 1'b0, 2, 5);
        issue(32'h103, 2'd1, 1'b1, 5'd13, 32'h00008811, 1'b0, 2, 5);
        issue(32'h101, 2'd1, 1'b0, 5'd14, 32'h00002233, 1'b0, 1, 3);

        // illegal size in XLEN=32
        issue(32'h100, 2'd3, 1'b0, 5'd15, 32'h0, 1'b1, 0, 1);

        // backpressure on both sides
        req_stall = 4; rsp_stall = 3;
        issue(32'h100, 2'd2, 1'b0, 5'd16, 32'h11223344, 1'b0, 1, 7);

        // reset while waiting on the second beat
        nreq = 0; bus_addr.delete(); hold_b1 = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h103; req_size = 2'd2; req_unsigned = 1'b0; req_tag = 5'd17;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (nreq < 2 && n < 20) begin @(negedge clk); n++; end
        chk("rst_test_two_reqs", 64'(nreq), 2);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        hold_b1 = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || mem_req_valid || !req_ready) bad = 1'b1;
        end
        chk("rst_late_rsp_dropped", bad, 0);

        // a normal load still works afterwards
        issue(32'h104, 2'd2, 1'b0, 5'd18, 32'h55667788, 1'b0, 1, 3);

        // misaligned-as-error instance (word 0x80FF7F01 on its bus)
        issue0(32'h101, 2'd1, 1'b0, 5'd20, 32'h0, 1'b1, 0, 1);
        issue0(32'h100, 2'd3, 1'b0, 5'd21, 32'h0, 1'b1, 0, 1);
        issue0(32'h102, 2'd2, 1'b1, 5'd22, 32'h0, 1'b1, 0, 1);
        issue0(32'h103, 2'd0, 1'b0, 5'd23, 32'hFFFFFF80, 1'b0, 1, 3);
        issue0(32'h102, 2'd1, 1'b0, 5'd24, 32'hFFFF80FF, 1'b0, 1, 3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
